// File: rtl/mul_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_unit_pkg
//   Shared definitions for the multiply/divide unit. The decoder, the hazard
//   unit and the unit itself all use these, so the op encoding and the
//   latencies stay in one place.
//   Contents:
//     md_op_e        op codes carried on md_op
//     md_state_e     sequencing states of the unit
//     MD_*_CYCLES    default busy durations
//     md_is_long_op  true for the multi-cycle ops (mult/multu/div/divu)
// -----------------------------------------------------------------------------
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;
  localparam int unsigned MD_CNT_W       = 5;

  function automatic logic md_is_long_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_arith.sv
// -----------------------------------------------------------------------------
// mul_div_unit_arith
//   Purely combinational arithmetic core of the multiply/divide unit.
//   Ports:
//     op_i           operation (md_op_e encoding)
//     a_i            rs operand: multiplicand / dividend
//     b_i            rt operand: multiplier / divisor
//     res_hi_o       product[63:32] or remainder
//     res_lo_o       product[31:0]  or quotient
//     div_by_zero_o  high for DIV/DIVU with b_i == 0 (result must not commit)
// -----------------------------------------------------------------------------
module mul_div_unit_arith
  import mul_div_unit_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div_by_zero_o
);

  md_op_e      op;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] num_mag;
  logic [31:0] den_mag;
  logic [31:0] den_safe;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign op = md_op_e'(op_i);

  // The low 64 bits of the product of sign-extended operands equal the
  // signed 64-bit product, so one unsigned multiplier shape serves both.
  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed divide works on magnitudes and fixes up signs afterwards:
  // quotient truncates toward zero, remainder takes the dividend's sign.
  // 0x80000000 negates to itself, which is its correct unsigned magnitude,
  // so 0x80000000 / -1 naturally yields 0x80000000 with remainder 0.
  assign signed_div = (op == MD_DIV);
  assign num_mag    = (signed_div && a_i[31]) ? -a_i : a_i;
  assign den_mag    = (signed_div && b_i[31]) ? -b_i : b_i;
  // Divisor forced to 1 on zero so the divider never sees x/0; the result
  // is discarded via div_by_zero_o anyway.
  assign den_safe   = (den_mag == 32'd0) ? 32'd1 : den_mag;
  assign quo_mag    = num_mag / den_safe;
  assign rem_mag    = num_mag % den_safe;
  assign quo        = (signed_div && (a_i[31] ^ b_i[31])) ? -quo_mag : quo_mag;
  assign rem        = (signed_div && a_i[31]) ? -rem_mag : rem_mag;

  assign div_by_zero_o = ((op == MD_DIV) || (op == MD_DIVU)) && (b_i == 32'd0);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; that is what keeps combinational blocks latch-free.
    res_hi_o = 32'd0;
    res_lo_o = 32'd0;
    case (op)
      MD_MULT:         {res_hi_o, res_lo_o} = prod_s;
      MD_MULTU:        {res_hi_o, res_lo_o} = prod_u;
      MD_DIV, MD_DIVU: begin
        res_hi_o = rem;
        res_lo_o = quo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Multiply/divide unit with architectural HI/LO for the EX stage.
//   mult/multu/div/divu run for a fixed number of cycles, then commit to
//   HI/LO; mthi/mtlo write in a single cycle.
//   Ports:
//     clk       clock, all state updates on posedge
//     reset     synchronous, active-high
//     md_start  request strobe; md_op/src_a/src_b sampled when high
//     md_op     operation (md_op_e encoding)
//     src_a     rs operand
//     src_b     rt operand
//     busy      registered; high while a mult/div is in flight
//     md_stall  busy, or a mult/div being requested this cycle
//     hi, lo    architectural HI/LO registers
// -----------------------------------------------------------------------------
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]           p_hi_q, p_hi_d;
  logic [31:0]           p_lo_q, p_lo_d;
  logic                  p_dz_q, p_dz_d;   // pending result is a divide by zero
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;

  md_op_e                op;
  logic                  start_long;
  logic [31:0]           res_hi;
  logic [31:0]           res_lo;
  logic                  div_by_zero;

  assign op         = md_op_e'(md_op);
  assign start_long = md_start && md_is_long_op(op);

  mul_div_unit_arith u_arith (
    .op_i          (md_op),
    .a_i           (src_a),
    .b_i           (src_b),
    .res_hi_o      (res_hi),
    .res_lo_o      (res_lo),
    .div_by_zero_o (div_by_zero)
  );

  // Next-state logic. Requests arriving in RUN are dropped: the hazard unit
  // never issues them, and ignoring them keeps the in-flight op intact.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    p_dz_d  = p_dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              p_hi_d  = res_hi;
              p_lo_d  = res_lo;
              p_dz_d  = 1'b0;
              cnt_d   = MD_CNT_W'(MULT_CYCLES);
              state_d = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              p_hi_d  = res_hi;
              p_lo_d  = res_lo;
              p_dz_d  = div_by_zero;
              cnt_d   = MD_CNT_W'(DIV_CYCLES);
              state_d = ST_RUN;
            end
            MD_MTHI: hi_d = src_a;
            MD_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        // cnt was loaded with N at the start edge, so the edge seeing 1 is
        // the N-th edge after it: busy has been high for exactly N cycles.
        if (cnt_q == MD_CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (!p_dz_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      p_dz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_dz_q  <= p_dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign md_stall = busy | start_long;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Self-checking bench for mul_div_unit: directed vectors with constant
//   expectations plus randomized ops checked against a 64-bit arithmetic
//   reference model of HI/LO.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  int bad_start_cnt = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mul_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Protocol monitor: a request while busy is illegal traffic.
  always @(posedge clk) begin
    if (!reset && md_start && busy) begin
      bad_start_cnt++;
      $display("note: protocol assertion - md_start while busy at %0t", $time);
    end
  end

  // Reference model: architectural effect of one request on {HI,LO}.
  function automatic logic [63:0] model_next(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: begin sp = sa * sb; return sp; end
      3'd2: begin up = ua * ub; return up; end
      3'd3: begin
        if (b == 32'd0) return {h, l};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {h, l};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd5:    return {a, l};
      3'd6:    return {h, a};
      default: return {h, l};
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 5;
    if (op == 3'd3 || op == 3'd4) return 10;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request, then counts busy cycles (bounded) and records
  // whether HI/LO held their pre-request values while busy.
  task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles, output bit hold_ok, output logic stall_seen);
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    pre_hi   = hi;
    pre_lo   = lo;
    cycles   = 0;
    hold_ok  = 1'b1;
    md_start = 1'b1;
    md_op    = op;
    src_a    = a;
    src_b    = b;
    #1;
    stall_seen = md_stall;
    tick();
    md_start = 1'b0;
    md_op    = 3'($urandom);
    src_a    = $urandom;
    src_b    = $urandom;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (hi !== pre_hi || lo !== pre_lo) hold_ok = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    md_start = 1'b0;
    md_op    = 3'd0;
    src_a    = '0;
    src_b    = '0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    reset = 1'b0;
    tick();
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", md_stall); end
  endtask

  task automatic test_mult();
    int cyc; bit hold; logic st;
    do_md(3'd1, 32'hFFFFFFFE, 32'd3, cyc, hold, st);
    checks++; if (cyc != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 5", cyc); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", lo); end
  endtask

  task automatic test_multu();
    int cyc; bit hold; logic st;
    do_md(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, hold, st);
    checks++; if (cyc != 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 5", cyc); end
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL multu_old_visible: got %b expected 1", hold); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
  endtask

  task automatic test_div();
    int cyc; bit hold; logic st;
    do_md(3'd3, 32'hFFFFFFF9, 32'd2, cyc, hold, st);
    checks++; if (cyc != 10) begin errors++; $display("FAIL div_busy_cycles: got %0d expected 10", cyc); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    do_md(3'd4, 32'd7, 32'd2, cyc, hold, st);
    checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h expected 3", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h expected 1", hi); end
    do_md(3'd3, 32'h80000000, 32'hFFFFFFFF, cyc, hold, st);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 0", hi); end
  endtask

  task automatic test_mt();
    bit busy_seen;
    md_start = 1'b1;
    md_op    = 3'd5;
    src_a    = 32'h12345678;
    #1;
    busy_seen = md_stall;
    tick();
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
    busy_seen = busy_seen | busy;
    md_op = 3'd6;
    src_a = 32'h9ABCDEF0;
    #1;
    busy_seen = busy_seen | md_stall;
    tick();
    md_start = 1'b0;
    busy_seen = busy_seen | busy;
    checks++; if (lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo_lo: got %h expected 9abcdef0", lo); end
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected 12345678", hi); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL mt_busy_or_stall: got %b expected 0", busy_seen); end
  endtask

  task automatic test_div_zero();
    int cyc; bit hold; logic st;
    do_md(3'd3, 32'd5, 32'd0, cyc, hold, st);
    checks++; if (cyc != 10) begin errors++; $display("FAIL divz_busy_cycles: got %0d expected 10", cyc); end
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL divz_hi: got %h expected 12345678", hi); end
    checks++; if (lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL divz_lo: got %h expected 9abcdef0", lo); end
  endtask

  task automatic test_reset_abort();
    bit late;
    md_start = 1'b1;
    md_op    = 3'd1;
    src_a    = 32'd6;
    src_b    = 32'd7;
    tick();
    md_start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL abort_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL abort_lo: got %h expected 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    late = 1'b0;
    repeat (8) begin
      tick();
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) late = 1'b1;
    end
    checks++; if (late !== 1'b0) begin errors++; $display("FAIL abort_late_commit: got %b expected 0", late); end
  endtask

  task automatic test_stall_back_to_back();
    int cyc; bit hold; logic st; int n;
    md_start = 1'b1;
    md_op    = 3'd1;
    src_a    = 32'd3;
    src_b    = 32'd4;
    #1;
    checks++; if (md_stall !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stall_start_cycle: got stall=%b busy=%b expected stall=1 busy=0", md_stall, busy); end
    tick();
    md_start = 1'b0;
    md_op    = 3'd0;
    checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL stall_tracks_busy: got %b expected 1", md_stall); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; tick(); end
    checks++; if (md_stall !== 1'b0 || lo !== 32'd12) begin errors++; $display("FAIL stall_release: got stall=%b lo=%h expected stall=0 lo=0000000c", md_stall, lo); end
    do_md(3'd1, 32'hFFFFFFFB, 32'd7, cyc, hold, st);
    checks++; if (cyc != 5) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 5", cyc); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFDD) begin errors++; $display("FAIL b2b_result: got %h_%h expected ffffffff_ffffffdd", hi, lo); end
  endtask

  task automatic test_busy_start();
    int cyc; bit hold; int bad0;
    bad0 = bad_start_cnt;
    md_start = 1'b1;
    md_op    = 3'd3;
    src_a    = 32'd100;
    src_b    = 32'd7;
    tick();
    md_start = 1'b0;
    cyc  = 0;
    hold = 1'b1;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFDD) hold = 1'b0;
      if (cyc == 2) begin md_start = 1'b1; md_op = 3'd5; src_a = 32'hDEADBEEF; end
      if (cyc == 3) begin md_op = 3'd1; src_a = 32'd9; src_b = 32'd9; end
      if (cyc == 4) md_start = 1'b0;
      tick();
    end
    md_start = 1'b0;
    checks++; if (cyc != 10) begin errors++; $display("FAIL busy_start_cycles: got %0d expected 10", cyc); end
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL busy_start_hold: got %b expected 1", hold); end
    checks++; if (hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL busy_start_result: got %h_%h expected 00000002_0000000e", hi, lo); end
    checks++; if (bad_start_cnt - bad0 != 2) begin errors++; $display("FAIL busy_start_flagged: got %0d expected 2", bad_start_cnt - bad0); end
    m_hi = 32'd2;
    m_lo = 32'd14;
  endtask

  task automatic test_random();
    int cyc; bit hold; logic st;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] nxt;
    int sel;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a   = (sel == 2) ? 32'h80000000 : $urandom;
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFFFFFF : $urandom;
      nxt = model_next(op, a, b, m_hi, m_lo);
      do_md(op, a, b, cyc, hold, st);
      checks++; if (cyc != model_latency(op)) begin errors++; $display("FAIL rnd%0d_cycles op=%0d: got %0d expected %0d", i, op, cyc, model_latency(op)); end
      checks++; if (st !== (model_latency(op) != 0)) begin errors++; $display("FAIL rnd%0d_stall op=%0d: got %b expected %b", i, op, st, model_latency(op) != 0); end
      checks++; if (model_latency(op) != 0 && hold !== 1'b1) begin errors++; $display("FAIL rnd%0d_hold op=%0d: got %b expected 1", i, op, hold); end
      checks++; if ({hi, lo} !== nxt) begin errors++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, op, a, b, hi, lo, nxt[63:32], nxt[31:0]); end
      m_hi = nxt[63:32];
      m_lo = nxt[31:0];
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mt();
    test_div_zero();
    test_reset_abort();
    test_stall_back_to_back();
    test_busy_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
